// File: rtl/neg.sv
// Two's-complement negation (b = -a) built as ~a + 1 on a two-level carry-lookahead incrementer.
// Latency: b/zero/ovf are combinational (zero cycles); ovf_sticky updates on the clock edge after ovf.
// Backpressure: none; pure datapath with no handshake, a new operand may be presented every cycle.
//
// Ports:
//   clk        - clock, only the sticky overflow register uses it
//   reset      - synchronous active-high, clears ovf_sticky
//   a          - signed operand
//   b          - -a mod 2^WIDTH
//   zero       - b == 0 (only possible for a == 0)
//   ovf        - a is the most-negative value, whose negation wraps back to itself
//   ovf_sticky - latched ovf, held until reset
//
// WIDTH must be a multiple of 4 and at least 4; the lookahead is organised in 4-bit groups.
module neg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             zero,
    output logic             ovf,
    output logic             ovf_sticky
);

    localparam int NGRP = WIDTH / 4;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Incrementing ~a: every bit propagates where ~a is 1, nothing generates,
    // and the carry into bit 0 is the +1.
    logic             cin;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gc;

    assign cin = 1'b1;
    assign p   = ~a;

    genvar gi, bi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            // Group propagate: all four bits pass the carry through.
            assign gp[gi] = &p[4*gi +: 4];

            // Second lookahead level: the carry into group gi is the input
            // carry ANDed with every lower group's propagate, computed flat
            // rather than rippled group to group.
            if (gi == 0) begin : g_first
                assign gc[gi] = cin;
            end else begin : g_rest
                assign gc[gi] = cin & (&gp[gi-1:0]);
            end

            // First lookahead level: carry into each bit of the group comes
            // straight from the group carry and the lower bits' propagates.
            for (bi = 0; bi < 4; bi++) begin : g_bit
                if (bi == 0) begin : g_b0
                    assign c[4*gi] = gc[gi];
                end else begin : g_bn
                    assign c[4*gi+bi] = gc[gi] & (&p[4*gi +: bi]);
                end
            end
        end
    endgenerate

    // With no generate terms the sum bit is propagate XOR carry-in. The carry
    // out of the MSB is never formed, so 0 negates to 0.
    assign b    = p ^ c;
    assign zero = ~|b;
    assign ovf  = (a == MOST_NEG);

    // Reset wins over a simultaneous ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (ovf) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_neg.sv
module tb_neg;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        zero;
    logic        ovf;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    neg #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .zero      (zero),
        .ovf       (ovf),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an operand and queue the reference-model expectation.
    task automatic drive(input logic [31:0] v);
        exp_t e;
        e.a    = v;
        e.b    = 32'h0 - v;
        e.zero = (v == 32'h0);
        e.ovf  = (v == 32'h8000_0000);
        a = v;
        exp_q.push_back(e);
    endtask

    // Let the combinational path settle, then pop and compare.
    task automatic check_out(input string tag);
        exp_t        e;
        logic [31:0] s;
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty: got b=%h required an entry", tag, b);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (b === e.b) else begin
                errors++;
                $error("FAIL %s b: a=%h got %h required %h", tag, e.a, b, e.b);
            end
            checks++;
            assert (zero === e.zero) else begin
                errors++;
                $error("FAIL %s zero: a=%h got %b required %b", tag, e.a, zero, e.zero);
            end
            checks++;
            assert (ovf === e.ovf) else begin
                errors++;
                $error("FAIL %s ovf: a=%h got %b required %b", tag, e.a, ovf, e.ovf);
            end
            s = b + e.a;
            checks++;
            assert (s === 32'h0) else begin
                errors++;
                $error("FAIL %s sum: a=%h b=%h got a+b=%h required 0", tag, e.a, b, s);
            end
        end
    endtask

    task automatic check_sticky(input string tag, input logic want);
        checks++;
        assert (ovf_sticky === want) else begin
            errors++;
            $error("FAIL %s ovf_sticky: got %b required %b", tag, ovf_sticky, want);
        end
    endtask

    initial begin
        reset = 1'b1;
        a     = 32'h0;

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_sticky("reset", 1'b0);
        reset = 1'b0;

        // Directed combinational cases.
        drive(32'h0000_0000); check_out("zero_in");
        drive(32'h0000_0005); check_out("pos5");
        drive(32'hFFFF_FFFB); check_out("neg5");
        drive(32'h7FFF_FFFF); check_out("max_pos");
        drive(32'h1234_5678); check_out("pattern");
        drive(32'h0000_0001); check_out("one");
        drive(32'hFFFF_FFFF); check_out("minus1");
        drive(32'h0000_0010); check_out("group_edge");
        drive(32'h0001_0000); check_out("mid_carry");

        // Hand-derived values, not via the model.
        drive(32'h1234_5678);
        #1;
        checks++;
        assert (b === 32'hEDCB_A988) else begin
            errors++;
            $error("FAIL const_pattern b: got %h required %h", b, 32'hEDCB_A988);
        end
        void'(exp_q.pop_front());
        drive(32'h7FFF_FFFF);
        #1;
        checks++;
        assert (b === 32'h8000_0001) else begin
            errors++;
            $error("FAIL const_max_pos b: got %h required %h", b, 32'h8000_0001);
        end
        void'(exp_q.pop_front());

        // Sticky sequence; sticky must still be clear since no ovf has been seen.
        @(negedge clk);
        check_sticky("pre_ovf", 1'b0);
        drive(32'h8000_0000); check_out("most_neg");
        checks++;
        assert (b === 32'h8000_0000) else begin
            errors++;
            $error("FAIL const_most_neg b: got %h required %h", b, 32'h8000_0000);
        end
        check_sticky("before_edge", 1'b0);
        @(negedge clk);
        check_sticky("set", 1'b1);
        drive(32'h0000_0001); check_out("after_ovf");
        @(negedge clk);
        check_sticky("hold", 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_sticky("cleared", 1'b0);
        reset = 1'b0;

        // Reset and ovf in the same cycle: reset wins, then ovf sets it.
        drive(32'h8000_0000); check_out("most_neg2");
        reset = 1'b1;
        @(negedge clk);
        check_sticky("reset_prio", 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_sticky("set_again", 1'b1);
        reset = 1'b1;
        drive(32'h0000_0000); check_out("zero_again");
        @(negedge clk);
        check_sticky("cleared2", 1'b0);
        reset = 1'b0;

        // Random sweep, each operand held for 10 ns with the check in between.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom());
            check_out("random");
            #9;
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain: got %0d entries left required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
